// File: rtl/mealy_seq_detect_ctrl.sv
// Programmable overlapping Mealy pattern detector with arm/count/stop control.
// Optional idle-cycle timeout is enabled by defining MATCH_TIMEOUT_EN.
module mealy_seq_detect_ctrl #(
  parameter int MAX_LEN     = 8,
  parameter int LEN_W       = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x,
  output logic               z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] word;
  logic [MAX_LEN-1:0] mask;
  logic               armed;
  logic               cap;
  logic               hit;
  logic               z_int;

`ifdef MATCH_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC) + 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              to_q, to_d;
  logic              idle_exp;
  assign idle_exp = idle_q == IDLE_W'(TIMEOUT_CYC - 1);
  assign timeout  = to_q;
`else
  assign timeout  = 1'b0;
`endif

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0)
      len_clamp = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))
      len_clamp = LEN_W'(MAX_LEN);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_q));
  end

  assign armed = state_q == S_ARMED;
  assign word  = {hist_q, x};
  assign cap   = cfg_valid & ~armed;

  // Newest bit x lines up with pattern bit 0.
  assign z_int = armed
              && (fill_q >= len_q - LEN_W'(1))
              && (((word ^ pat_q) & mask) == '0);

  assign hit = z_int && (tgt_q != '0)
            && (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1})
                == {1'b0, tgt_q});

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    tgt_d   = tgt_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
`ifdef MATCH_TIMEOUT_EN
    idle_d  = idle_q;
    to_d    = to_q;
`endif
    if (cap) begin
      pat_d = cfg_pattern;
      len_d = len_clamp;
      tgt_d = cfg_target;
    end
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_ARMED;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
`ifdef MATCH_TIMEOUT_EN
          idle_d  = '0;
          to_d    = 1'b0;
`endif
        end
      end
      S_ARMED: begin
        hist_d = word[MAX_LEN-2:0];
        if (fill_q != LEN_W'(MAX_LEN - 1))
          fill_d = fill_q + LEN_W'(1);
        if (z_int && cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
`ifdef MATCH_TIMEOUT_EN
        if (z_int)
          idle_d = '0;
        else if (!idle_exp)
          idle_d = idle_q + IDLE_W'(1);
`endif
        if (stop)
          state_d = S_IDLE;
        else if (hit)
          state_d = S_DONE;
`ifdef MATCH_TIMEOUT_EN
        else if (!z_int && idle_exp) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      tgt_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
`ifdef MATCH_TIMEOUT_EN
      idle_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      tgt_q   <= tgt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
`ifdef MATCH_TIMEOUT_EN
      idle_q  <= idle_d;
      to_q    <= to_d;
`endif
    end
  end

  assign z         = z_int;
  assign busy      = armed;
  assign done      = state_q == S_DONE;
  assign cfg_ready = ~armed;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_seq_detect_ctrl.sv
// Self-checking bench for mealy_seq_detect_ctrl.
// Directed scenarios plus randomized traffic against a bit-queue model.
module tb_mealy_seq_detect_ctrl;

  localparam int TO = 8;
`ifdef MATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, start, stop, x;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       cfg_ready, z, busy, done, timeout;
  logic [7:0] match_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 armed, 2 done
  int         m_mode;
  logic [7:0] m_pat;
  int         m_len, m_tgt, m_cnt, m_idle;
  bit         m_to;
  bit         m_bits[$];

  bit   z_exp;
  logic z_obs;

  mealy_seq_detect_ctrl #(
    .MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target),
    .start(start), .stop(stop), .x(x),
    .z(z), .busy(busy), .done(done),
    .match_cnt(match_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode = 0; m_pat = 8'h00; m_len = 1; m_tgt = 0;
    m_cnt = 0; m_idle = 0; m_to = 1'b0;
    m_bits.delete();
  endtask

  function automatic bit model_z(bit xv);
    bit b;
    if (m_mode != 1) return 1'b0;
    if (m_bits.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? xv : m_bits[m_bits.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(bit xv, bit zv, bit sv, bit pv, bit cv);
    if (cv && m_mode != 1) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
      m_tgt = int'(cfg_target);
    end
    if (m_mode == 1) begin
      m_bits.push_back(xv);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      if (zv && m_cnt < 255) m_cnt++;
    end
    if (pv) m_mode = 0;
    else if (sv && m_mode != 1) begin
      m_mode = 1; m_bits.delete();
      m_cnt = 0; m_idle = 0; m_to = 1'b0;
    end else if (m_mode == 1) begin
      if (zv && m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
      else if (TO_EN) begin
        if (zv) m_idle = 0;
        else if (m_idle == TO - 1) begin m_mode = 2; m_to = 1'b1; end
        else m_idle++;
      end
    end
  endtask

  // One clock: drive at negedge, sample z, step model at posedge.
  task automatic cycle(bit xv, bit sv, bit pv, bit cv);
    @(negedge clk);
    x = xv; start = sv; stop = pv; cfg_valid = cv;
    #1;
    z_obs = z;
    z_exp = model_z(xv);
    @(posedge clk);
    model_edge(xv, z_exp, sv, pv, cv);
    #1;
  endtask

  task automatic set_cfg(logic [7:0] p, logic [3:0] l, logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_target = t;
  endtask

  task automatic test_reset();
    rst = 1'b0; x = 0; start = 0; stop = 0; cfg_valid = 0;
    set_cfg(8'h00, 4'd0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({z, busy, done, timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {z, busy, done, timeout});
    end
    checks++;
    if (cfg_ready !== 1'b1 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_rdy_cnt: got %b/%0d want 1/0", cfg_ready, match_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_overlap();
    logic [19:0] s;
    bit ok;
    s = 20'b11011110010111101111;
    ok = 1'b1;
    set_cfg(8'b00101111, 4'd6, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      cycle(s[20-k], 0, 0, 0);
      checks++;
      if (z_obs !== (k == 7 || k == 15 || k == 20)) begin
        errors++;
        $display("FAIL overlap_z k=%0d: got %b", k, z_obs);
      end
      if (busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (match_cnt !== 8'd3 || !ok) begin
      errors++;
      $display("FAIL overlap_cnt: got %0d busy_ok=%b want 3/1", match_cnt, ok);
    end
  endtask

  task automatic test_fill();
    cycle(0, 0, 1, 0);
    set_cfg(8'b11, 4'd2, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (z_obs !== (k >= 2)) begin
        errors++;
        $display("FAIL fill11_z k=%0d: got %b want %b", k, z_obs, k >= 2);
      end
    end
    checks++;
    if (match_cnt !== 8'd4) begin
      errors++;
      $display("FAIL fill11_cnt: got %0d want 4", match_cnt);
    end
    cycle(0, 0, 1, 0);
    set_cfg(8'b000, 4'd3, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 0, 0, 0);
      checks++;
      if (z_obs !== (k == 3)) begin
        errors++;
        $display("FAIL fill000_z k=%0d: got %b want %b", k, z_obs, k == 3);
      end
    end
  endtask

  task automatic test_target();
    logic [5:0] s;
    s = 6'b101011;
    cycle(0, 0, 1, 0);
    set_cfg(8'b101, 4'd3, 8'd2);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      cycle(s[6-k], 0, 0, 0);
      checks++;
      if (z_obs !== (k == 3 || k == 5)) begin
        errors++;
        $display("FAIL target_z k=%0d: got %b", k, z_obs);
      end
      if (k == 5) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL target_done: got d=%b b=%b r=%b want 1 0 1",
                   done, busy, cfg_ready);
        end
      end
    end
    checks++;
    if (match_cnt !== 8'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL target_cnt: got %0d/%b want 2/1", match_cnt, done);
    end
  endtask

  task automatic test_cfg();
    logic [2:0]  s3;
    logic [10:0] s8;
    s3 = 3'b101;
    set_cfg(8'b101, 4'd3, 8'd0);
    cycle(0, 1, 0, 1);
    set_cfg(8'b000, 4'd3, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle(s3[3-k], 0, 0, 1);
      checks++;
      if (z_obs !== (k == 3) || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL armed_cfg k=%0d: got z=%b rdy=%b", k, z_obs, cfg_ready);
      end
    end
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_stop: got b=%b d=%b r=%b want 0 0 1",
               busy, done, cfg_ready);
    end
    set_cfg(8'b1, 4'd0, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      cycle(k != 2, 0, 0, 0);
      checks++;
      if (z_obs !== (k != 2)) begin
        errors++;
        $display("FAIL len0 k=%0d: got %b want %b", k, z_obs, k != 2);
      end
    end
    cycle(0, 0, 1, 0);
    s8 = 11'b10110011011;
    set_cfg(8'b10110011, 4'd12, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      cycle(s8[11-k], 0, 0, 0);
      checks++;
      if (z_obs !== (k == 8)) begin
        errors++;
        $display("FAIL len12 k=%0d: got %b want %b", k, z_obs, k == 8);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 0);
    set_cfg(8'b11, 4'd2, 8'd0);
    cycle(0, 1, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    @(negedge clk);
    x = 1; start = 0; stop = 0; cfg_valid = 0;
    #1;
    checks++;
    if (z !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_z: got %b want 1", z);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({z, busy, done, timeout, cfg_ready} !== 5'b00001
        || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: got %b cnt=%0d want 00001 cnt=0",
               {z, busy, done, timeout, cfg_ready}, match_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (z_obs !== 1'b1) begin
      errors++;
      $display("FAIL rst_pat0 x=0: got %b want 1", z_obs);
    end
    cycle(1, 0, 0, 0);
    checks++;
    if (z_obs !== 1'b0 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL rst_pat0 x=1: got %b cnt=%0d want 0 cnt=1",
               z_obs, match_cnt);
    end
  endtask

  task automatic test_timeout();
    bit exp_done;
    cycle(0, 0, 1, 0);
    set_cfg(8'b11, 4'd2, 8'd0);
    cycle(0, 1, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 0, 0);
      exp_done = TO_EN && k >= TO;
      checks++;
      if (done !== exp_done || timeout !== exp_done || busy !== !exp_done) begin
        errors++;
        $display("FAIL timeout k=%0d: got d=%b t=%b b=%b want %b %b %b",
                 k, done, timeout, busy, exp_done, exp_done, !exp_done);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 1500; n++) begin
      set_cfg(8'($urandom), 4'($urandom_range(0, 10)),
              8'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 0)
        cfg_len = 4'($urandom_range(1, 3));
      cycle(1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0);
      checks++;
      if (z_obs !== z_exp) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_z n=%0d: got %b want %b", n, z_obs, z_exp);
      end
      checks++;
      if (match_cnt !== 8'(m_cnt) || busy !== (m_mode == 1)
          || done !== (m_mode == 2) || cfg_ready !== (m_mode != 1)
          || timeout !== m_to) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_state n=%0d: got cnt=%0d b=%b d=%b r=%b t=%b want cnt=%0d mode=%0d t=%b",
                   n, match_cnt, busy, done, cfg_ready, timeout,
                   m_cnt, m_mode, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_fill();
    test_target();
    test_cfg();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
